// File: rtl/bridge_tx.sv
// Response serializer for the Manta host bridge: turns a read-data word into the
// ASCII frame 'M', uppercase hex digits (MS nibble first), CR, LF for the UART transmitter.
module bridge_tx #(
  parameter int          DATA_WIDTH = 16,
  parameter logic [7:0]  PREAMBLE   = 8'h4D
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic                  rw_i,
  input  logic                  valid_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  busy_o,
  output logic                  overrun_o
);

  localparam int N  = DATA_WIDTH / 4;
  localparam int NW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, PRE, DATA, CR, LF} state_t;

  state_t                state;
  logic [NW-1:0]         nib_idx;
  logic [DATA_WIDTH-1:0] data_q;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [3:0] nibble(input logic [DATA_WIDTH-1:0] d,
                                        input logic [NW-1:0] k);
    logic [DATA_WIDTH-1:0] s;
    s = d >> {k, 2'b00};
    return s[3:0];
  endfunction

  // The next byte is loaded on each handshake, so tx_data_o only moves when a byte is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      nib_idx    <= '0;
      data_q     <= '0;
      tx_data_o  <= 8'h00;
      tx_valid_o <= 1'b0;
      busy_o     <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      if (valid_i && !rw_i && state != IDLE)
        overrun_o <= 1'b1;

      case (state)
        IDLE: begin
          if (valid_i && !rw_i) begin
            data_q     <= rdata_i;
            state      <= PRE;
            tx_data_o  <= PREAMBLE;
            tx_valid_o <= 1'b1;
            busy_o     <= 1'b1;
          end
        end
        PRE: begin
          if (tx_ready_i) begin
            state     <= DATA;
            nib_idx   <= NW'(N - 1);
            tx_data_o <= hex_char(nibble(data_q, NW'(N - 1)));
          end
        end
        DATA: begin
          if (tx_ready_i) begin
            if (nib_idx == '0) begin
              state     <= CR;
              tx_data_o <= 8'h0D;
            end else begin
              nib_idx   <= nib_idx - NW'(1);
              tx_data_o <= hex_char(nibble(data_q, nib_idx - NW'(1)));
            end
          end
        end
        CR: begin
          if (tx_ready_i) begin
            state     <= LF;
            tx_data_o <= 8'h0A;
          end
        end
        LF: begin
          if (tx_ready_i) begin
            state      <= IDLE;
            tx_data_o  <= 8'h00;
            tx_valid_o <= 1'b0;
            busy_o     <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          tx_valid_o <= 1'b0;
          busy_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bridge_tx.sv
// Directed bench for bridge_tx: frames, backpressure, ignored writes, overrun,
// back-to-back boundary and mid-frame reset.
module tb_bridge_tx;

  logic        clk;
  logic        rst_n;
  logic [15:0] rdata_i;
  logic        rw_i;
  logic        valid_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        busy_o;
  logic        overrun_o;

  int assert_count = 0;
  int fail_count   = 0;

  logic [7:0] frame [7];
  int         cycles;

  bridge_tx #(.DATA_WIDTH(16), .PREAMBLE(8'h4D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rdata_i    (rdata_i),
    .rw_i       (rw_i),
    .valid_i    (valid_i),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .busy_o     (busy_o),
    .overrun_o  (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    assert_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_idle(input string tag, input logic exp_overrun);
    check_output({tag, " tx_valid"}, 32'(tx_valid_o), 32'(1'b0));
    check_output({tag, " busy"},     32'(busy_o),     32'(1'b0));
    check_output({tag, " overrun"},  32'(overrun_o),  32'(exp_overrun));
  endtask

  // Drive a one-cycle read request; rdata_i is scrambled afterwards to prove it was latched.
  task automatic apply_stimulus(input logic [15:0] d);
    @(negedge clk);
    rdata_i = d;
    rw_i    = 1'b0;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    rdata_i = ~d;
  endtask

  task automatic recv_frame(input string tag, input logic [7:0] exp [7], input int nbytes,
                            input int period, input bit inject, input logic [15:0] inj,
                            output int used);
    int idx;
    idx  = 0;
    used = 0;
    while (idx < nbytes && used < 200) begin
      @(negedge clk);
      tx_ready_i = ((used % period) == period - 1);
      check_output(tag, {23'd0, tx_valid_o, tx_data_o}, {23'd0, 1'b1, exp[idx]});
      if (tx_valid_o && tx_ready_i) begin
        if (inject && idx == nbytes - 1) begin
          valid_i = 1'b1;
          rw_i    = 1'b0;
          rdata_i = inj;
        end
        idx++;
      end
      used++;
    end
    check_output({tag, " count"}, 32'(idx), 32'(nbytes));
  endtask

  initial begin
    rst_n      = 1'b0;
    rdata_i    = '0;
    rw_i       = 1'b0;
    valid_i    = 1'b0;
    tx_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_idle("reset", 1'b0);
    check_output("reset tx_data", 32'(tx_data_o), 32'h00);
    rst_n = 1'b1;

    $display("[TB] basic read");
    tx_ready_i = 1'b1;
    apply_stimulus(16'h12AB);
    frame = '{8'h4D, 8'h31, 8'h32, 8'h41, 8'h42, 8'h0D, 8'h0A};
    recv_frame("basic", frame, 7, 1, 1'b0, 16'h0, cycles);
    check_output("basic cycles", 32'(cycles), 32'd7);
    @(negedge clk);
    check_idle("basic end", 1'b0);

    $display("[TB] backpressure");
    apply_stimulus(16'hF00D);
    frame = '{8'h4D, 8'h46, 8'h30, 8'h30, 8'h44, 8'h0D, 8'h0A};
    recv_frame("backpressure", frame, 7, 3, 1'b0, 16'h0, cycles);
    check_output("backpressure cycles", 32'(cycles), 32'd21);
    @(negedge clk);
    check_idle("backpressure end", 1'b0);

    $display("[TB] write ignored");
    @(negedge clk);
    rdata_i = 16'hBEEF;
    rw_i    = 1'b1;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    rw_i    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check_output("write valid", 32'(tx_valid_o), 32'(1'b0));
      check_output("write busy",  32'(busy_o),     32'(1'b0));
      @(negedge clk);
    end

    $display("[TB] overrun");
    tx_ready_i = 1'b0;
    apply_stimulus(16'h0001);
    apply_stimulus(16'h0002);
    @(negedge clk);
    check_output("overrun flag", 32'(overrun_o), 32'(1'b1));
    check_output("overrun busy", 32'(busy_o), 32'(1'b1));
    check_output("overrun held", 32'(tx_data_o), 32'h4D);
    frame = '{8'h4D, 8'h30, 8'h30, 8'h30, 8'h31, 8'h0D, 8'h0A};
    recv_frame("overrun", frame, 7, 1, 1'b0, 16'h0, cycles);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_idle("overrun after", 1'b1);
    end

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("overrun reset", 1'b0);

    $display("[TB] back-to-back boundary");
    tx_ready_i = 1'b1;
    apply_stimulus(16'h0000);
    frame = '{8'h4D, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
    recv_frame("b2b first", frame, 7, 1, 1'b1, 16'hFFFF, cycles);
    @(negedge clk);
    check_idle("b2b dropped", 1'b1);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    rdata_i = 16'h0000;
    frame = '{8'h4D, 8'h46, 8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A};
    recv_frame("b2b second", frame, 7, 1, 1'b0, 16'h0, cycles);

    $display("[TB] reset mid-frame");
    apply_stimulus(16'h1234);
    frame = '{8'h4D, 8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
    recv_frame("midframe", frame, 3, 1, 1'b0, 16'h0, cycles);
    @(negedge clk);
    rst_n      = 1'b0;
    tx_ready_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("midframe reset", 1'b0);
    check_output("midframe tx_data", 32'(tx_data_o), 32'h00);
    tx_ready_i = 1'b1;
    @(negedge clk);
    check_output("midframe abandoned", 32'(tx_valid_o), 32'(1'b0));
    apply_stimulus(16'h5A5A);
    frame = '{8'h4D, 8'h35, 8'h41, 8'h35, 8'h41, 8'h0D, 8'h0A};
    recv_frame("after reset", frame, 7, 1, 1'b0, 16'h0, cycles);
    @(negedge clk);
    check_idle("after reset end", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
